// File: rtl/gf16_sched_pkg.sv
// Shared types, constants and GF(2^4) helpers for the inverter scheduler.
// Field polynomial is x^4 + x + 1.
package gf16_sched_pkg;

  typedef logic [3:0] gf16_t;

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  localparam int RND_W      = 12;
  localparam int RND_R0_LSB = 0;
  localparam int RND_R1_LSB = 4;
  localparam int RND_R2_LSB = 8;

  // Shift-and-add multiply; a carry out of bit 3 folds back as x + 1.
  function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
    gf16_t p;
    gf16_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // Squaring is linear in characteristic 2, so it can be applied per share.
  function automatic gf16_t gf16_sq(input gf16_t a);
    return gf16_mul(a, a);
  endfunction

  // Exhaustive search for the multiplicative inverse; 0 maps to 0.
  function automatic gf16_t gf16_inv_ref(input gf16_t x);
    gf16_t r;
    r = '0;
    for (int y = 1; y < 16; y++) begin
      if (gf16_mul(x, 4'(y)) == 4'h1) r = 4'(y);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf16_inv_sched_if.sv
// Request, randomness and result handshakes between the requesters and the scheduler.
interface gf16_inv_sched_if;
  import gf16_sched_pkg::*;

  logic             a_valid;
  logic             a_ready;
  gf16_t            a_in0;
  gf16_t            a_in1;
  logic             b_valid;
  logic             b_ready;
  gf16_t            b_in0;
  gf16_t            b_in1;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [RND_W-1:0] rnd;
  logic             a_out_valid;
  logic             a_out_ready;
  gf16_t            a_out0;
  gf16_t            a_out1;
  logic             b_out_valid;
  logic             b_out_ready;
  gf16_t            b_out0;
  gf16_t            b_out1;
  logic             busy;

  modport master (
    output a_valid, a_in0, a_in1, b_valid, b_in0, b_in1,
           rnd_valid, rnd, a_out_ready, b_out_ready,
    input  a_ready, b_ready, rnd_ready,
           a_out_valid, a_out0, a_out1, b_out_valid, b_out0, b_out1, busy
  );

  modport slave (
    input  a_valid, a_in0, a_in1, b_valid, b_in0, b_in1,
           rnd_valid, rnd, a_out_ready, b_out_ready,
    output a_ready, b_ready, rnd_ready,
           a_out_valid, a_out0, a_out1, b_out_valid, b_out0, b_out1, busy
  );

endinterface

// File: rtl/GF16_inv.sv
// Two-share masked GF(2^4) inverter, one register stage.
// inv(x) = x^14 = x^2 * x^4 * x^8; the squarings are linear and done per share,
// the three-way product is split into its eight share cross terms, each cross
// pair is remasked with one randomness nibble and registered before recombining.
module GF16_inv
  import gf16_sched_pkg::*;
(
  input  logic             CLK,
  input  gf16_t            x0,
  input  gf16_t            x1,
  input  logic [RND_W-1:0] rnd,
  output gf16_t            y0,
  output gf16_t            y1
);

  gf16_t a0, a1, b0, b1, c0, c1;
  gf16_t r0, r1, r2;
  gf16_t t000, t001, t010, t011;
  gf16_t t111, t110, t101, t100;

  assign a0 = gf16_sq(x0);
  assign a1 = gf16_sq(x1);
  assign b0 = gf16_sq(a0);
  assign b1 = gf16_sq(a1);
  assign c0 = gf16_sq(b0);
  assign c1 = gf16_sq(b1);

  assign r0 = rnd[RND_R0_LSB +: 4];
  assign r1 = rnd[RND_R1_LSB +: 4];
  assign r2 = rnd[RND_R2_LSB +: 4];

  // Register every partial product so masked cross terms never meet combinationally.
  always_ff @(posedge CLK) begin
    t000 <= gf16_mul(gf16_mul(a0, b0), c0);
    t001 <= gf16_mul(gf16_mul(a0, b0), c1) ^ r0;
    t010 <= gf16_mul(gf16_mul(a0, b1), c0) ^ r1;
    t011 <= gf16_mul(gf16_mul(a0, b1), c1) ^ r2;
    t111 <= gf16_mul(gf16_mul(a1, b1), c1);
    t110 <= gf16_mul(gf16_mul(a1, b1), c0) ^ r0;
    t101 <= gf16_mul(gf16_mul(a1, b0), c1) ^ r1;
    t100 <= gf16_mul(gf16_mul(a1, b0), c0) ^ r2;
  end

  assign y0 = t000 ^ t001 ^ t010 ^ t011;
  assign y1 = t111 ^ t110 ^ t101 ^ t100;

endmodule

// File: rtl/gf16_rr_arb2.sv
// Two-input round-robin arbiter. ptr selects the winner on a tie
// (0 = req[0], 1 = req[1]) and then points at the loser.
module gf16_rr_arb2 #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After any grant the other input gets priority; otherwise hold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)       ptr <= FIRST_PRIO;
    else if (|gnt)   ptr <= gnt[0];
  end

endmodule

// File: rtl/gf16_inv_sched.sv
// Shares one masked GF16 inverter between lanes A and B. Issues need a fresh
// randomness word, a clear in-flight bit for the lane and room in its slot.
// Results land in a per-lane one-entry slot two cycles after the handshake.
module gf16_inv_sched
  import gf16_sched_pkg::*;
#(
  parameter bit ZERO_IDLE  = 1'b1,
  parameter bit FIRST_PRIO = 1'b0
) (
  input logic              CLK,
  input logic              RSTn,
  gf16_inv_sched_if.slave  bus
);

  logic             infl_v;
  lane_e            infl_tag;
  logic             infl_a, infl_b;
  logic             can_a, can_b;
  logic [1:0]       gnt;
  logic             issue;

  gf16_t            inv_in0, inv_in1;
  logic [RND_W-1:0] inv_rnd;
  gf16_t            inv_out0, inv_out1;

  logic             slot_a_v, slot_b_v;
  gf16_t            slot_a0, slot_a1, slot_b0, slot_b1;

  assign infl_a = infl_v & (infl_tag == LANE_A);
  assign infl_b = infl_v & (infl_tag == LANE_B);

  // A full slot only blocks its lane when downstream is not draining it this cycle.
  assign can_a = bus.a_valid & bus.rnd_valid & ~infl_a & (~slot_a_v | bus.a_out_ready);
  assign can_b = bus.b_valid & bus.rnd_valid & ~infl_b & (~slot_b_v | bus.b_out_ready);

  gf16_rr_arb2 #(
    .FIRST_PRIO (FIRST_PRIO)
  ) u_arb (
    .CLK  (CLK),
    .RSTn (RSTn),
    .req  ({can_b, can_a}),
    .gnt  (gnt)
  );

  assign issue         = |gnt;
  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.rnd_ready = issue;

  // Steer the granted lane into the inverter; idle cycles optionally present all zeros.
  always_comb begin
    inv_in0 = gnt[1] ? bus.b_in0 : bus.a_in0;
    inv_in1 = gnt[1] ? bus.b_in1 : bus.a_in1;
    inv_rnd = bus.rnd;
    if (ZERO_IDLE && !issue) begin
      inv_in0 = '0;
      inv_in1 = '0;
      inv_rnd = '0;
    end
  end

  GF16_inv u_inv (
    .CLK (CLK),
    .x0  (inv_in0),
    .x1  (inv_in1),
    .rnd (inv_rnd),
    .y0  (inv_out0),
    .y1  (inv_out1)
  );

  // Tag the inverter register contents with the lane that issued them.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      infl_v   <= 1'b0;
      infl_tag <= LANE_A;
    end else begin
      infl_v   <= issue;
      infl_tag <= gnt[1] ? LANE_B : LANE_A;
    end
  end

  // Lane A slot: an arriving result wins over a same-cycle pop.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slot_a_v <= 1'b0;
      slot_a0  <= '0;
      slot_a1  <= '0;
    end else if (infl_a) begin
      slot_a_v <= 1'b1;
      slot_a0  <= inv_out0;
      slot_a1  <= inv_out1;
    end else if (slot_a_v && bus.a_out_ready) begin
      slot_a_v <= 1'b0;
      slot_a0  <= '0;
      slot_a1  <= '0;
    end
  end

  // Lane B slot: same policy as lane A.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slot_b_v <= 1'b0;
      slot_b0  <= '0;
      slot_b1  <= '0;
    end else if (infl_b) begin
      slot_b_v <= 1'b1;
      slot_b0  <= inv_out0;
      slot_b1  <= inv_out1;
    end else if (slot_b_v && bus.b_out_ready) begin
      slot_b_v <= 1'b0;
      slot_b0  <= '0;
      slot_b1  <= '0;
    end
  end

  assign bus.a_out_valid = slot_a_v;
  assign bus.a_out0      = slot_a0;
  assign bus.a_out1      = slot_a1;
  assign bus.b_out_valid = slot_b_v;
  assign bus.b_out0      = slot_b0;
  assign bus.b_out1      = slot_b1;
  assign bus.busy        = infl_v | slot_a_v | slot_b_v;

endmodule

// File: tb/tb_gf16_inv_sched.sv
// Bench for gf16_inv_sched: table-driven single issues, directed arbitration
// sequences and a long random run against a per-lane result-queue model.
`timescale 1ns/1ps
module tb_gf16_inv_sched;
  import gf16_sched_pkg::*;

  localparam bit FP = 1'b0;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  gf16_inv_sched_if bus ();

  gf16_inv_sched #(
    .ZERO_IDLE  (1'b1),
    .FIRST_PRIO (FP)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each lane holds a queue of results in issue order, each tagged with
  // the first cycle it is visible at the output (issue cycle + 2).
  typedef struct {
    logic [3:0] val;
    int         rdy;
  } res_t;

  res_t q[2][$];
  bit   prio;
  int   cyc = 0;

  task automatic model_clear();
    q[0].delete();
    q[1].delete();
    prio = FP;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    bus.a_valid     = 1'b0;
    bus.b_valid     = 1'b0;
    bus.a_in0       = '0;
    bus.a_in1       = '0;
    bus.b_in0       = '0;
    bus.b_in1       = '0;
    bus.rnd_valid   = 1'b0;
    bus.rnd         = '0;
    bus.a_out_ready = 1'b1;
    bus.b_out_ready = 1'b1;
  endtask

  task automatic rand_ins();
    bus.a_in0 = 4'($urandom_range(0, 15));
    bus.a_in1 = 4'($urandom_range(0, 15));
    bus.b_in0 = 4'($urandom_range(0, 15));
    bus.b_in1 = 4'($urandom_range(0, 15));
    bus.rnd   = 12'($urandom_range(0, 4095));
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    set_idle();
    tick();
    tick();
    RSTn = 1'b1;
    model_clear();
  endtask

  // Called once per cycle after inputs are driven: compares, then advances the model.
  task automatic check_cycle();
    bit full[2], infl[2], can[2], g[2], val[2], ordy[2];
    logic [3:0] x[2], o0[2], o1[2];
    logic ov[2], rdy[2];
    #2;
    val[0]  = bus.a_valid;      val[1]  = bus.b_valid;
    ordy[0] = bus.a_out_ready;  ordy[1] = bus.b_out_ready;
    x[0]    = bus.a_in0 ^ bus.a_in1;
    x[1]    = bus.b_in0 ^ bus.b_in1;
    rdy[0]  = bus.a_ready;      rdy[1]  = bus.b_ready;
    ov[0]   = bus.a_out_valid;  ov[1]   = bus.b_out_valid;
    o0[0]   = bus.a_out0;       o0[1]   = bus.b_out0;
    o1[0]   = bus.a_out1;       o1[1]   = bus.b_out1;
    for (int l = 0; l < 2; l++) begin
      full[l] = (q[l].size() > 0) && (q[l][0].rdy <= cyc);
      infl[l] = (q[l].size() > 0) && (q[l][q[l].size()-1].rdy == cyc + 1);
      can[l]  = val[l] && bus.rnd_valid && !infl[l] && (!full[l] || ordy[l]);
    end
    g = can;
    if (can[0] && can[1]) begin
      g[0] = (prio == 1'b0);
      g[1] = (prio == 1'b1);
    end
    chk("a_ready", rdy[0], g[0]);
    chk("b_ready", rdy[1], g[1]);
    chk("rnd_ready", bus.rnd_ready, g[0] | g[1]);
    for (int l = 0; l < 2; l++) begin
      chk(l ? "b_out_valid" : "a_out_valid", ov[l], full[l]);
      if (full[l]) chk(l ? "b_out_xor" : "a_out_xor", o0[l] ^ o1[l], q[l][0].val);
      else         chk(l ? "b_out_zero" : "a_out_zero", {o0[l], o1[l]}, 8'h00);
    end
    chk("busy", bus.busy, (q[0].size() > 0) || (q[1].size() > 0));
    if (!(g[0] || g[1])) chk("idle_inv_in", {dut.inv_in0, dut.inv_in1, dut.inv_rnd}, 20'h0);
    else                 chk("issue_inv_rnd", dut.inv_rnd, bus.rnd);
    for (int l = 0; l < 2; l++) begin
      if (full[l] && ordy[l]) void'(q[l].pop_front());
      if (g[l]) begin
        q[l].push_back('{val: gf16_inv_ref(x[l]), rdy: cyc + 2});
        prio = (l == 0);
      end
    end
    cyc++;
  endtask

  typedef struct {
    bit          lane;
    logic [3:0]  x0;
    logic [3:0]  x1;
    logic [11:0] r;
    logic [3:0]  exp;
  } vec_t;

  vec_t vt[7];
  int   res_cnt;
  logic [11:0] cons[$];
  logic [11:0] expw[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // lane, share0, share1, rnd, expected inverse of share0^share1
    vt[0] = '{1'b0, 4'h6, 4'h5, 12'hA5C, 4'hE};
    vt[1] = '{1'b0, 4'h3, 4'h3, 12'h123, 4'h0};
    vt[2] = '{1'b1, 4'h0, 4'h2, 12'hFFF, 4'h9};
    vt[3] = '{1'b1, 4'h9, 4'h0, 12'h000, 4'h2};
    vt[4] = '{1'b0, 4'hF, 4'h0, 12'h777, 4'h8};
    vt[5] = '{1'b1, 4'h1, 4'hC, 12'h5A5, 4'h4};
    vt[6] = '{1'b0, 4'h4, 4'h3, 12'h0F0, 4'h6};

    do_reset();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_outs", {bus.a_out_valid, bus.b_out_valid, bus.a_out0, bus.a_out1,
                       bus.b_out0, bus.b_out1}, 18'h0);

    // Single issues from the table.
    foreach (vt[k]) begin
      chk("ref_table", gf16_inv_ref(vt[k].x0 ^ vt[k].x1), vt[k].exp);
      tick();
      set_idle();
      bus.rnd_valid = 1'b1;
      bus.rnd       = vt[k].r;
      if (vt[k].lane) begin
        bus.b_valid = 1'b1; bus.b_in0 = vt[k].x0; bus.b_in1 = vt[k].x1;
      end else begin
        bus.a_valid = 1'b1; bus.a_in0 = vt[k].x0; bus.a_in1 = vt[k].x1;
      end
      #2;
      chk("vec_ready", vt[k].lane ? bus.b_ready : bus.a_ready, 1'b1);
      chk("vec_other_ready", vt[k].lane ? bus.a_ready : bus.b_ready, 1'b0);
      chk("vec_rnd_ready", bus.rnd_ready, 1'b1);
      tick();
      set_idle();
      #2;
      chk("vec_t1_valid", vt[k].lane ? bus.b_out_valid : bus.a_out_valid, 1'b0);
      chk("vec_t1_busy", bus.busy, 1'b1);
      chk("vec_t1_rnd_ready", bus.rnd_ready, 1'b0);
      tick();
      #2;
      chk("vec_t2_valid", vt[k].lane ? bus.b_out_valid : bus.a_out_valid, 1'b1);
      chk("vec_t2_xor", vt[k].lane ? (bus.b_out0 ^ bus.b_out1) : (bus.a_out0 ^ bus.a_out1),
          vt[k].exp);
      tick();
      #2;
      chk("vec_t3_valid", vt[k].lane ? bus.b_out_valid : bus.a_out_valid, 1'b0);
      chk("vec_t3_zero", vt[k].lane ? {bus.b_out0, bus.b_out1} : {bus.a_out0, bus.a_out1}, 8'h0);
      chk("vec_t3_busy", bus.busy, 1'b0);
    end

    // Both lanes continuously requesting: strict alternation from FIRST_PRIO.
    do_reset();
    res_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      set_idle();
      rand_ins();
      bus.a_valid   = (i < 20);
      bus.b_valid   = (i < 20);
      bus.rnd_valid = 1'b1;
      check_cycle();
      if (i < 20) begin
        chk("alt_a", bus.a_ready, ((i % 2) == 0) != FP);
        chk("alt_b", bus.b_ready, ((i % 2) == 1) != FP);
      end
      res_cnt += int'(bus.a_out_valid) + int'(bus.b_out_valid);
    end
    chk("alt_results", res_cnt, 20);

    // Randomness toggling: no grant without a word, pointer frozen meanwhile.
    do_reset();
    cons.delete();
    expw.delete();
    for (int i = 0; i < 16; i++) begin
      tick();
      set_idle();
      rand_ins();
      bus.a_valid   = 1'b1;
      bus.b_valid   = 1'b1;
      bus.rnd_valid = ((i % 2) == 0);
      bus.rnd       = 12'(i * 37 + 5);
      check_cycle();
      if ((i % 2) == 0) expw.push_back(bus.rnd);
      chk("tog_a", bus.a_ready, (i % 4) == 0);
      chk("tog_b", bus.b_ready, (i % 4) == 2);
      if (bus.rnd_ready) cons.push_back(bus.rnd);
    end
    chk("tog_words", cons.size(), expw.size());
    for (int k = 0; k < cons.size() && k < expw.size(); k++) chk("tog_word", cons[k], expw[k]);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_idle();
      check_cycle();
    end

    // Lane B slot stuck full: only A progresses, every other cycle.
    do_reset();
    tick();
    set_idle();
    rand_ins();
    bus.b_valid     = 1'b1;
    bus.rnd_valid   = 1'b1;
    bus.b_out_ready = 1'b0;
    check_cycle();
    chk("stall_b_first", bus.b_ready, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      rand_ins();
      bus.a_valid = 1'b1;
      check_cycle();
      chk("stall_b_blocked", bus.b_ready, 1'b0);
      chk("stall_a_rate", bus.a_ready, (i % 2) == 1);
    end
    tick();
    rand_ins();
    bus.a_valid     = 1'b0;
    bus.b_out_ready = 1'b1;
    check_cycle();
    chk("release_b_ready", bus.b_ready, 1'b1);
    chk("release_b_pop", bus.b_out_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      set_idle();
      check_cycle();
    end

    // Reset the cycle after an A issue: the result is dropped.
    do_reset();
    tick();
    set_idle();
    rand_ins();
    bus.a_valid   = 1'b1;
    bus.rnd_valid = 1'b1;
    check_cycle();
    chk("rst_issue", bus.a_ready, 1'b1);
    tick();
    set_idle();
    RSTn = 1'b0;
    model_clear();
    check_cycle();
    tick();
    RSTn = 1'b1;
    check_cycle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_cycle();
      chk("rst_a_out_valid", bus.a_out_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
    end
    chk("rst_ptr", dut.u_arb.ptr, FP);
    tick();
    rand_ins();
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.rnd_valid = 1'b1;
    check_cycle();
    chk("rst_first_grant", bus.a_ready, !FP);
    for (int i = 0; i < 4; i++) begin
      tick();
      set_idle();
      check_cycle();
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      tick();
      rand_ins();
      bus.a_valid     = ($urandom_range(0, 3) != 0);
      bus.b_valid     = ($urandom_range(0, 3) != 0);
      bus.rnd_valid   = ($urandom_range(0, 3) != 0);
      bus.a_out_ready = ($urandom_range(0, 2) != 0);
      bus.b_out_ready = ($urandom_range(0, 2) != 0);
      check_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      set_idle();
      check_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
